anton_neopixel_decoder: RTL and testbench
=========================================

// Module: anton_neopixel_decoder
// PURPOSE
//  Receive side of the 7MHz NeoPixel single-wire link: samples neoData, decodes bits from
//  high-pulse width and assembles 24-bit pixels. Detects the reset/latch gap that ends a frame.
//  Used as a loopback checker for the transmitter and as the front end of a strip-snooping peripheral.
//  Also recovers the 8-bit B2G3R3 source value from each 24-bit pixel.
// PARAMETERS
//  PIXELS_MAX      66   max pixels accepted per frame; later pixels are dropped and flagged
//  T1_MIN_TICKS    4    high width >= this decodes as 1; 1..T1_MIN_TICKS-1 decodes as 0
//  MAX_HIGH_TICKS  8    high width reaching this is a stuck-high error
//  RESET_TICKS     350  low run reaching this ends the frame (50us @ 7MHz)
//  PIXELS_BITS     `CLOG2(PIXELS_MAX) (localparam)
// PORTS
//  clk7mhz       in   1            sole clock, 7MHz
//  reset         in   1            synchronous, active-high
//  neoData       in   1            async serial line, idle low
//  pixelValid    out  1            1-cycle strobe; the pixel outputs below are valid
//  pixelData     out  24           received pixel; first bit on the wire lands in bit 0
//  pixel8bit     out  8            compacted B2G3R3 value (mapping below)
//  pixelCompact  out  1            1 = all non-mapped pixelData bits are 0 (lossless)
//  pixelIndex    out  PIXELS_BITS  index of the pixel in the current frame, 0-based
//  frameDone     out  1            1-cycle strobe at the end of the reset gap
//  pixelCount    out  PIXELS_BITS+1 complete pixels in the frame; valid with frameDone
//  errStrobe     out  1            1-cycle strobe on any error
//  errCode       out  2            0 stuck-high, 1 partial pixel, 2 overflow; held until the next error
//  inReset       out  1            1 while the line is low >= RESET_TICKS (latch phase)
// BEHAVIOUR
//  - All outputs are 0 during reset and in the cycle after it. State goes to SYNC and counters clear.
//  - neoData passes through a 2-FF synchroniser (s2) plus a previous-value reg (s3) for edge detect.
//  - Widths are counted in clk7mhz cycles of s2. Counters saturate and never wrap.
//  - FSM:
//    SYNC: count s2 low; on reaching RESET_TICKS go to IDLE. Any high clears the count.
//          Decoding starts only at a frame boundary.
//    IDLE: inReset=1. On an s2 rise, go to HIGH with hcnt=1.
//    HIGH: hcnt++ while s2 is high.
//          hcnt==MAX_HIGH_TICKS: errStrobe, errCode=0, discard the partial pixel, go to SYNC.
//          s2 fall: shift bit (hcnt>=T1_MIN_TICKS) into pixelData[bitcnt], bitcnt++, go to LOW with lcnt=1.
//    LOW:  lcnt++. On an s2 rise, go to HIGH with hcnt=1.
//          lcnt==RESET_TICKS: pulse frameDone and go to IDLE. If bitcnt!=0, also pulse errStrobe
//          with errCode=1, drop the partial bits and exclude them from pixelCount.
//  - Pixel completion on the 24th bit:
//    - bitcnt wraps to 0.
//    - If pixelCount<PIXELS_MAX: pixelValid=1, pixelIndex=pixelCount, then pixelCount++.
//    - Else: no pixelValid; errStrobe with errCode=2 once per frame; pixelCount holds.
//  - Latency: pixelValid is high exactly 3 cycles after the first clk edge that samples neoData low
//    at the end of the 24th high pulse. frameDone follows the same 2-cycle sync offset.
//  - pixelData, pixel8bit and pixelCompact hold their value until the next pixelValid.
//  - pixelCount and pixelIndex clear on the cycle after frameDone.
//  - Compaction: pixel8bit = {d[17],d[18],d[3],d[2],d[1],d[9],d[10],d[11]} (MSB..LSB).
//    pixelCompact = ~|(d & ~24'h060E0E).
//  - Simultaneous events: errors take priority over pixelValid in the same cycle.
//    A stuck-high during SYNC is not an error.
//  - reset mid-frame: partial data is discarded with no strobes, and the block waits in SYNC.
// TESTING
//  - reset, 400 low, then 24 bits of pattern 24'h060E0E (2/6 and 5/3 ticks), 400 low
//    -> pixelValid once; pixelData=060E0E; pixel8bit=FF; pixelCompact=1; frameDone; pixelCount=1.
//  - 3 pixels (8bit 00, A5, 3C expanded as in the transmitter), then 400 low
//    -> pixelIndex 0,1,2; pixel8bit matches each; pixelCount=3.
//  - 12 bits, then 400 low -> errStrobe, errCode=1, no pixelValid, frameDone with pixelCount=0.
//  - line held high for 20 cycles mid-pixel -> errStrobe, errCode=0 at the 8th high tick.
//    No frameDone until 350 low cycles have passed, then normal decode resumes.
//  - PIXELS_MAX=2, send 3 pixels -> 2 pixelValid, one errStrobe with errCode=2, pixelCount=2.
//  - loopback: transmitter driving neoData from a preloaded buffer
//    -> the pixel8bit sequence equals the buffer contents.

Source files
------------

// File: rtl/anton_neopixel_decoder.sv
// NeoPixel receive decoder: pulse-width bit recovery, 24-bit pixel assembly,
// latch-gap frame detection and B2G3R3 recovery from each pixel.
module anton_neopixel_decoder #(
   parameter  int PIXELS_MAX     = 66,
   parameter  int T1_MIN_TICKS   = 4,
   parameter  int MAX_HIGH_TICKS = 8,
   parameter  int RESET_TICKS    = 350,
   localparam int PIXELS_BITS    = $clog2(PIXELS_MAX)
) (
   input  logic                   clk7mhz,
   input  logic                   reset,
   input  logic                   neoData,
   output logic                   pixelValid,
   output logic [23:0]            pixelData,
   output logic [7:0]             pixel8bit,
   output logic                   pixelCompact,
   output logic [PIXELS_BITS-1:0] pixelIndex,
   output logic                   frameDone,
   output logic [PIXELS_BITS:0]   pixelCount,
   output logic                   errStrobe,
   output logic [1:0]             errCode,
   output logic                   inReset
);

   localparam int HW  = $clog2(MAX_HIGH_TICKS + 1);
   localparam int CW  = $clog2(RESET_TICKS + 1);
   localparam int PCW = PIXELS_BITS + 1;

   localparam logic [HW-1:0]  H_T1  = HW'(T1_MIN_TICKS);
   localparam logic [HW-1:0]  H_END = HW'(MAX_HIGH_TICKS - 1);
   localparam logic [CW-1:0]  L_END = CW'(RESET_TICKS - 1);
   localparam logic [PCW-1:0] P_MAX = PCW'(PIXELS_MAX);

   typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

   logic                   r_s1, r_s2, r_s3;
   state_t                 r_state;
   logic [HW-1:0]          r_hcnt;
   logic [CW-1:0]          r_lcnt;
   logic [4:0]             r_bitcnt;
   logic [23:0]            r_shift;
   logic [PCW-1:0]         r_pcount;
   logic                   r_ovf;

   logic                   r_ev_pix;
   logic [PIXELS_BITS-1:0] r_ev_idx;
   logic [23:0]            r_ev_data;
   logic                   r_ev_frame;
   logic                   r_ev_err;
   logic [1:0]             r_ev_code;

   logic                   w_rise;
   logic                   w_bit;
   logic                   w_last;
   logic [23:0]            w_word;
   logic [7:0]             w_p8;
   logic                   w_cmp;

   assign w_rise = r_s2 & ~r_s3;
   assign w_bit  = (r_hcnt >= H_T1);
   assign w_last = (r_bitcnt == 5'd23);

   always_comb begin
      w_word           = r_shift;
      w_word[r_bitcnt] = w_bit;
   end

   assign w_p8 = {r_ev_data[17], r_ev_data[18], r_ev_data[3], r_ev_data[2],
                  r_ev_data[1], r_ev_data[9], r_ev_data[10], r_ev_data[11]};
   assign w_cmp = ~|(r_ev_data & ~24'h060E0E);

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= neoData;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         r_state    <= SYNC;
         r_hcnt     <= '0;
         r_lcnt     <= '0;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_pcount   <= '0;
         r_ovf      <= 1'b0;
         r_ev_pix   <= 1'b0;
         r_ev_idx   <= '0;
         r_ev_data  <= '0;
         r_ev_frame <= 1'b0;
         r_ev_err   <= 1'b0;
         r_ev_code  <= '0;
      end else begin
         r_ev_pix   <= 1'b0;
         r_ev_frame <= 1'b0;
         r_ev_err   <= 1'b0;
         unique case (r_state)
            SYNC: begin
               r_bitcnt <= '0;
               r_pcount <= '0;
               r_ovf    <= 1'b0;
               if (r_s2) begin
                  r_lcnt <= '0;
               end else if (r_lcnt == L_END) begin
                  r_lcnt  <= '0;
                  r_state <= IDLE;
               end else begin
                  r_lcnt <= r_lcnt + 1'b1;
               end
            end
            IDLE: begin
               r_bitcnt <= '0;
               r_pcount <= '0;
               r_ovf    <= 1'b0;
               if (w_rise) begin
                  r_hcnt  <= HW'(1);
                  r_state <= HIGH;
               end
            end
            HIGH: begin
               if (r_s2) begin
                  if (r_hcnt == H_END) begin
                     r_ev_err  <= 1'b1;
                     r_ev_code <= 2'd0;
                     r_lcnt    <= '0;
                     r_state   <= SYNC;
                  end else begin
                     r_hcnt <= r_hcnt + 1'b1;
                  end
               end else begin
                  r_shift <= w_word;
                  r_lcnt  <= CW'(1);
                  r_state <= LOW;
                  if (w_last) begin
                     r_bitcnt <= '0;
                     if (r_pcount < P_MAX) begin
                        r_ev_pix  <= 1'b1;
                        r_ev_idx  <= r_pcount[PIXELS_BITS-1:0];
                        r_ev_data <= w_word;
                        r_pcount  <= r_pcount + 1'b1;
                     end else if (!r_ovf) begin
                        // overflow is reported once, later pixels drop silently
                        r_ovf     <= 1'b1;
                        r_ev_err  <= 1'b1;
                        r_ev_code <= 2'd2;
                     end
                  end else begin
                     r_bitcnt <= r_bitcnt + 5'd1;
                  end
               end
            end
            LOW: begin
               if (w_rise) begin
                  r_hcnt  <= HW'(1);
                  r_state <= HIGH;
               end else if (r_lcnt == L_END) begin
                  r_ev_frame <= 1'b1;
                  r_lcnt     <= '0;
                  r_state    <= IDLE;
                  if (r_bitcnt != 5'd0) begin
                     r_ev_err  <= 1'b1;
                     r_ev_code <= 2'd1;
                  end
               end else begin
                  r_lcnt <= r_lcnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         pixelValid   <= 1'b0;
         pixelData    <= '0;
         pixel8bit    <= '0;
         pixelCompact <= 1'b0;
         pixelIndex   <= '0;
         frameDone    <= 1'b0;
         pixelCount   <= '0;
         errStrobe    <= 1'b0;
         errCode      <= '0;
         inReset      <= 1'b0;
      end else begin
         pixelValid <= r_ev_pix & ~r_ev_err;
         if (r_ev_pix & ~r_ev_err) begin
            pixelData    <= r_ev_data;
            pixel8bit    <= w_p8;
            pixelCompact <= w_cmp;
            pixelIndex   <= r_ev_idx;
         end else if (frameDone) begin
            pixelIndex <= '0;
         end
         // live count lags one cycle so it is still intact alongside frameDone
         frameDone  <= r_ev_frame;
         pixelCount <= r_pcount;
         errStrobe  <= r_ev_err;
         if (r_ev_err) begin
            errCode <= r_ev_code;
         end
         inReset <= (r_state == IDLE);
      end
   end

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Bench for anton_neopixel_decoder: random pulse widths on neoData, expected
// strobes and timings derived from a frame-level model of the link.
module tb_anton_neopixel_decoder;

   typedef struct packed {
      logic [1:0]  kind;
      logic [19:0] cyc;
      logic [7:0]  val;
      logic [23:0] data;
      logic [7:0]  p8;
      logic        flag;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   logic neoData;

   logic        pv0, pc0, fd0, es0, ir0;
   logic [23:0] pd0;
   logic [7:0]  p80;
   logic [6:0]  pi0;
   logic [7:0]  cnt0;
   logic [1:0]  ec0;

   logic        pv1, pc1, fd1, es1, ir1;
   logic [23:0] pd1;
   logic [7:0]  p81;
   logic [0:0]  pi1;
   logic [1:0]  cnt1;
   logic [1:0]  ec1;

   int vec  = 0;
   int errs = 0;
   int cyc  = 0;

   int   pm[2] = '{66, 2};
   bit   m_active;
   int   m_bits;
   int   m_pix;
   int   m_last;
   logic [23:0] m_word;

   ev_t got0[$], got1[$], exp0[$], exp1[$];

   anton_neopixel_decoder u_dut (
      .clk7mhz(clk), .reset(reset), .neoData(neoData),
      .pixelValid(pv0), .pixelData(pd0), .pixel8bit(p80),
      .pixelCompact(pc0), .pixelIndex(pi0), .frameDone(fd0),
      .pixelCount(cnt0), .errStrobe(es0), .errCode(ec0),
      .inReset(ir0)
   );

   anton_neopixel_decoder #(.PIXELS_MAX(2)) u_dut2 (
      .clk7mhz(clk), .reset(reset), .neoData(neoData),
      .pixelValid(pv1), .pixelData(pd1), .pixel8bit(p81),
      .pixelCompact(pc1), .pixelIndex(pi1), .frameDone(fd1),
      .pixelCount(cnt1), .errStrobe(es1), .errCode(ec1),
      .inReset(ir1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int k, input int c, input int v,
                              input logic [23:0] d, input logic [7:0] p,
                              input logic f);
      ev_t e;
      e.kind = k[1:0];
      e.cyc  = c[19:0];
      e.val  = v[7:0];
      e.data = d;
      e.p8   = p;
      e.flag = f;
      return e;
   endfunction

   always @(negedge clk) begin
      if (pv0) got0.push_back(mk(1, cyc, int'(pi0), pd0, p80, pc0));
      if (fd0) got0.push_back(mk(2, cyc, int'(cnt0), 24'h0, 8'h0, ir0));
      if (es0) got0.push_back(mk(3, cyc, int'(ec0), 24'h0, 8'h0, 1'b0));
      if (pv1) got1.push_back(mk(1, cyc, int'(pi1), pd1, p81, pc1));
      if (fd1) got1.push_back(mk(2, cyc, int'(cnt1), 24'h0, 8'h0, ir1));
      if (es1) got1.push_back(mk(3, cyc, int'(ec1), 24'h0, 8'h0, 1'b0));
   end

   function automatic logic [7:0] p8_of(input logic [23:0] w);
      return {w[17], w[18], w[3], w[2], w[1], w[9], w[10], w[11]};
   endfunction

   function automatic logic [23:0] expand(input logic [7:0] b);
      logic [23:0] w;
      w = '0;
      w[17] = b[7]; w[18] = b[6]; w[3]  = b[5]; w[2]  = b[4];
      w[1]  = b[3]; w[9]  = b[2]; w[10] = b[1]; w[11] = b[0];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int d, input ev_t e);
      if (d == 0) exp0.push_back(e);
      else exp1.push_back(e);
   endtask

   task automatic drive(input logic lvl, input int n);
      neoData = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int h, input int l,
                           input logic [7:0] p8x, input logic cx);
      int fall;
      int pos;
      drive(1'b1, h);
      fall = cyc;
      if (m_active) begin
         pos = m_bits % 24;
         m_word[pos] = b;
         m_bits++;
         if (pos == 23) begin
            for (int d = 0; d < 2; d++) begin
               if (m_pix < pm[d])
                  push_exp(d, mk(1, fall + 4, m_pix, m_word, p8x, cx));
               else if (m_pix == pm[d])
                  push_exp(d, mk(3, fall + 4, 2, 24'h0, 8'h0, 1'b0));
            end
            m_pix++;
         end
      end
      m_last = fall;
      drive(1'b0, l);
   endtask

   // mode 0: random widths, 1: fixed transmitter widths, 2: decode thresholds
   task automatic send_pixel(input logic [23:0] w, input logic [7:0] p8x,
                             input logic cx, input int mode);
      int h, l;
      for (int i = 0; i < 24; i++) begin
         if (mode == 1) begin
            h = w[i] ? 5 : 2;
            l = w[i] ? 3 : 6;
         end else if (mode == 2) begin
            h = w[i] ? ($urandom_range(1, 0) ? 4 : 7)
                     : ($urandom_range(1, 0) ? 3 : 1);
            l = 1;
         end else begin
            h = w[i] ? $urandom_range(7, 4) : $urandom_range(3, 1);
            l = $urandom_range(8, 1);
         end
         send_bit(w[i], h, l, p8x, cx);
      end
   endtask

   task automatic send_rand_pixel();
      logic [23:0] w;
      w = 24'($urandom);
      send_pixel(w, p8_of(w), ((w & ~24'h060E0E) == 24'h0), 0);
   endtask

   task automatic send_bits(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = 1'($urandom_range(1, 0));
         send_bit(b, b ? $urandom_range(7, 4) : $urandom_range(3, 1),
                  $urandom_range(8, 1), 8'h0, 1'b0);
      end
   endtask

   task automatic gap(input int n);
      int c;
      if (!m_active) begin
         m_active = 1'b1;
      end else if (m_bits > 0) begin
         for (int d = 0; d < 2; d++) begin
            c = (m_pix < pm[d]) ? m_pix : pm[d];
            push_exp(d, mk(2, m_last + 353, c, 24'h0, 8'h0, 1'b1));
            if (m_bits % 24 != 0)
               push_exp(d, mk(3, m_last + 353, 1, 24'h0, 8'h0, 1'b0));
         end
      end
      m_bits = 0;
      m_pix  = 0;
      drive(1'b0, n);
   endtask

   task automatic stuck(input int n);
      int c0;
      c0 = cyc;
      if (m_active && n >= 8) begin
         for (int d = 0; d < 2; d++)
            push_exp(d, mk(3, c0 + 11, 0, 24'h0, 8'h0, 1'b0));
      end
      m_active = 1'b0;
      m_bits   = 0;
      m_pix    = 0;
      drive(1'b1, n);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      neoData = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_out0", {pv0, pd0, p80, pc0, pi0, fd0, cnt0, es0, ec0, ir0}, 64'h0);
      chk("rst_out1", {pv1, pd1, p81, pc1, pi1, fd1, cnt1, es1, ec1, ir1}, 64'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst0", {pv0, pd0, p80, pc0, pi0, fd0, cnt0, es0, ec0, ir0}, 64'h0);
      chk("post_rst1", {pv1, pd1, p81, pc1, pi1, fd1, cnt1, es1, ec1, ir1}, 64'h0);
      m_active = 1'b0;
      m_bits   = 0;
      m_pix    = 0;
   endtask

   task automatic chk_all(input string tag);
      ev_t g[$];
      ev_t e[$];
      #1;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            g = got0;
            e = exp0;
         end else begin
            g = got1;
            e = exp1;
         end
         chk($sformatf("%s.d%0d.count", tag, d), 64'(g.size()), 64'(e.size()));
         for (int i = 0; i < e.size() && i < g.size(); i++)
            chk($sformatf("%s.d%0d.ev%0d", tag, d, i), {1'b0, g[i]}, {1'b0, e[i]});
      end
      got0.delete();
      got1.delete();
      exp0.delete();
      exp1.delete();
   endtask

   initial begin
      logic [7:0] buffer [8];
      int np, nb;

      m_word = '0;
      do_reset();
      gap(400);
      chk_all("sync");
      chk("idle_inReset", ir0, 1);

      send_pixel(24'h060E0E, 8'hFF, 1'b1, 1);
      chk("busy_inReset", ir0, 0);
      gap(400);
      chk_all("frameA");
      chk("hold_data", pd0, 24'h060E0E);
      chk("hold_p8", p80, 8'hFF);
      chk("hold_cmp", pc0, 1);
      chk("after_inReset", ir0, 1);

      send_pixel(expand(8'h00), 8'h00, 1'b1, 0);
      send_pixel(expand(8'hA5), 8'hA5, 1'b1, 0);
      send_pixel(expand(8'h3C), 8'h3C, 1'b1, 0);
      gap(400);
      chk_all("frameB");
      chk("idx_cleared", pi0, 0);
      chk("cnt_cleared", cnt0, 0);
      chk("ovf_code_held", ec1, 2);

      send_bits(12);
      gap(400);
      chk_all("partial");
      chk("partial_code_held", ec0, 1);

      send_rand_pixel();
      send_bits(12);
      stuck(20);
      gap(400);
      send_rand_pixel();
      send_rand_pixel();
      gap(400);
      chk_all("stuck");
      chk("stuck_code_held", ec0, 0);

      send_bits(10);
      do_reset();
      send_bits(5);
      gap(400);
      send_rand_pixel();
      gap(400);
      chk_all("midreset");

      begin
         logic [23:0] w;
         w = 24'($urandom);
         send_pixel(w, p8_of(w), ((w & ~24'h060E0E) == 24'h0), 2);
         w = 24'($urandom);
         send_pixel(w, p8_of(w), ((w & ~24'h060E0E) == 24'h0), 2);
      end
      gap(400);
      chk_all("thresholds");

      for (int i = 0; i < 8; i++) buffer[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) send_pixel(expand(buffer[i]), buffer[i], 1'b1, 1);
      gap(400);
      chk_all("loopback");

      for (int r = 0; r < 3; r++) begin
         np = $urandom_range(3, 0);
         nb = $urandom_range(1, 0) ? $urandom_range(23, 1) : 0;
         for (int i = 0; i < np; i++) send_rand_pixel();
         send_bits(nb);
         gap(400);
         chk_all($sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
